// File: rtl/ttl_sync_counter.sv
// Parametrised synchronous up/down counter in the 74xx163/191 style.
// Parallel load, cascade enables, ripple-carry out and registered wrap flag.
module ttl_sync_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             VCC,
    input  logic             GND,
    input  logic             LOAD_N,
    input  logic [WIDTH-1:0] D,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             UP,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             WRAP
);

    if (WIDTH < 1 || MODULUS < 2 ||
        64'(MODULUS) > (64'(1) << WIDTH)) begin : g_bad_param
        $error("ttl_sync_counter: illegal WIDTH/MODULUS");
    end

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             powered;
    logic             tc;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;

    assign powered = VCC & ~GND;
    assign tc      = UP ? (Q == TOP) : (Q == '0);
    assign RCO     = powered & ENT & tc;

    // Out-of-range loaded values wrap on the next up step via the >= test.
    always_comb begin
        q_nxt    = Q;
        wrap_nxt = 1'b0;
        if (RST) begin
            q_nxt = '0;
        end else if (!LOAD_N) begin
            q_nxt = D;
        end else if (ENP && ENT) begin
            if (UP) begin
                if (Q >= TOP) begin
                    q_nxt    = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    q_nxt = Q + ONE;
                end
            end else begin
                if (Q == '0) begin
                    q_nxt    = TOP;
                    wrap_nxt = 1'b1;
                end else begin
                    q_nxt = Q - ONE;
                end
            end
        end
    end

    // Unpowered edges are ignored entirely, reset included.
    always_ff @(posedge CLK) begin
        if (powered) begin
            Q    <= q_nxt;
            WRAP <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_ttl_sync_counter.sv
// Bench for ttl_sync_counter: vector table on a modulus-10 counter,
// plus cascade and modulus-2 sequences, all checked via scoreboards.
module tb_ttl_sync_counter;

    typedef struct {
        logic       vcc;
        logic       gnd;
        logic       rst;
        logic       load_n;
        logic [3:0] d;
        logic       enp;
        logic       ent;
        logic       up;
        logic [3:0] q;
        logic       wrap;
        logic       rco;
    } vec_t;

    typedef struct {
        logic [3:0] q;
        logic       wrap;
        logic       rco;
    } exp_t;

    typedef struct {
        logic [7:0] cnt;
        logic       m_q;
        logic       m_wrap;
    } cexp_t;

    int tests = 0;
    int fails = 0;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       vcc = 1'b1;
    logic       gnd = 1'b0;
    logic       rst = 1'b1;
    logic       load_n = 1'b1;
    logic [3:0] d = 4'd0;
    logic       enp = 1'b0;
    logic       ent = 1'b1;
    logic       up = 1'b0;
    logic [3:0] q;
    logic       rco;
    logic       wrap;

    ttl_sync_counter #(.WIDTH(4), .MODULUS(10)) u_dec (
        .CLK(CLK), .RST(rst), .VCC(vcc), .GND(gnd),
        .LOAD_N(load_n), .D(d), .ENP(enp), .ENT(ent),
        .UP(up), .Q(q), .RCO(rco), .WRAP(wrap)
    );

    logic       c_rst = 1'b1;
    logic       c_one = 1'b1;
    logic       c_zero = 1'b0;
    logic [3:0] c_d = 4'd0;
    logic       m_d = 1'b0;
    logic [3:0] q0, q1;
    logic       rco0, rco1, wrap0, wrap1;
    logic       m_q, m_rco, m_wrap;

    ttl_sync_counter #(.WIDTH(4)) u_c0 (
        .CLK(CLK), .RST(c_rst), .VCC(c_one), .GND(c_zero),
        .LOAD_N(c_one), .D(c_d), .ENP(c_one), .ENT(c_one),
        .UP(c_one), .Q(q0), .RCO(rco0), .WRAP(wrap0)
    );

    ttl_sync_counter #(.WIDTH(4)) u_c1 (
        .CLK(CLK), .RST(c_rst), .VCC(c_one), .GND(c_zero),
        .LOAD_N(c_one), .D(c_d), .ENP(c_one), .ENT(rco0),
        .UP(c_one), .Q(q1), .RCO(rco1), .WRAP(wrap1)
    );

    ttl_sync_counter #(.WIDTH(1), .MODULUS(2)) u_m2 (
        .CLK(CLK), .RST(c_rst), .VCC(c_one), .GND(c_zero),
        .LOAD_N(c_one), .D(m_d), .ENP(c_one), .ENT(c_one),
        .UP(c_one), .Q(m_q), .RCO(m_rco), .WRAP(m_wrap)
    );

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic vec_t mk(
        input logic vcc_i, input logic gnd_i,
        input logic rst_i, input logic load_n_i,
        input logic [3:0] d_i, input logic enp_i,
        input logic ent_i, input logic up_i,
        input logic [3:0] q_i, input logic wrap_i,
        input logic rco_i);
        vec_t v;
        v.vcc = vcc_i;   v.gnd = gnd_i;
        v.rst = rst_i;   v.load_n = load_n_i;
        v.d = d_i;       v.enp = enp_i;
        v.ent = ent_i;   v.up = up_i;
        v.q = q_i;       v.wrap = wrap_i;
        v.rco = rco_i;
        return v;
    endfunction

    function automatic vec_t cnt(input logic up_i,
                                 input logic [3:0] q_i,
                                 input logic wrap_i,
                                 input logic rco_i);
        return mk(1, 0, 0, 1, 4'd0, 1, 1, up_i, q_i, wrap_i, rco_i);
    endfunction

    vec_t  vecs[$];
    exp_t  sb[$];
    cexp_t csb[$];

    initial begin
        exp_t       e;
        cexp_t      ce;
        logic [3:0] q0_prev, q1_prev;
        logic [3:0] qq;

        // reset while powered; RCO = ENT & ~UP at Q=0
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1));
        for (int i = 1; i <= 12; i++) begin
            qq = 4'(i % 10);
            vecs.push_back(cnt(1, qq, qq == 0, qq == 9));
        end
        // unpowered edges: RST and LOAD_N ignored
        vecs.push_back(mk(0, 0, 1, 0, 5, 1, 1, 1, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 5, 1, 1, 1, 2, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 5, 1, 1, 1, 2, 0, 0));
        // load 3 then count down through the wrap
        vecs.push_back(mk(1, 0, 0, 0, 3, 1, 1, 0, 3, 0, 0));
        vecs.push_back(cnt(0, 2, 0, 0));
        vecs.push_back(cnt(0, 1, 0, 0));
        vecs.push_back(cnt(0, 0, 0, 1));
        vecs.push_back(cnt(0, 9, 1, 0));
        vecs.push_back(cnt(0, 8, 0, 0));
        // priority: RST over load over count
        vecs.push_back(mk(1, 0, 1, 0, 7, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 7, 1, 1, 1, 7, 0, 0));
        vecs.push_back(cnt(1, 8, 0, 0));
        vecs.push_back(cnt(1, 9, 0, 1));
        vecs.push_back(cnt(1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1));
        // out-of-range loads
        vecs.push_back(mk(1, 0, 0, 0, 13, 1, 1, 1, 13, 0, 0));
        vecs.push_back(cnt(1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 13, 1, 1, 0, 13, 0, 0));
        vecs.push_back(cnt(0, 12, 0, 0));
        // power loss freezes Q and WRAP, resume afterwards
        vecs.push_back(mk(1, 0, 0, 0, 9, 1, 1, 1, 9, 0, 1));
        vecs.push_back(cnt(1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 1, 0, 1, 0));
        vecs.push_back(cnt(1, 1, 0, 0));

        foreach (vecs[i]) begin
            @(negedge CLK);
            vcc = vecs[i].vcc;   gnd = vecs[i].gnd;
            rst = vecs[i].rst;   load_n = vecs[i].load_n;
            d = vecs[i].d;       enp = vecs[i].enp;
            ent = vecs[i].ent;   up = vecs[i].up;
            e.q = vecs[i].q;
            e.wrap = vecs[i].wrap;
            e.rco = vecs[i].rco;
            sb.push_back(e);
            @(posedge CLK);
            #1;
            e = sb.pop_front();
            check($sformatf("v%0d_q", i), 32'(q), 32'(e.q));
            check($sformatf("v%0d_wrap", i), 32'(wrap), 32'(e.wrap));
            check($sformatf("v%0d_rco", i), 32'(rco), 32'(e.rco));
        end

        // RCO follows UP combinationally at Q=1 (neither terminal)
        @(negedge CLK);
        enp = 1'b0; ent = 1'b1; up = 1'b0;
        #1 check("rco_comb_dn", 32'(rco), 32'(0));

        // cascade and modulus-2 sequences
        check("casc_reset", 32'({q1, q0}), 32'(0));
        check("m2_reset_wrap", 32'(m_wrap), 32'(0));
        @(negedge CLK);
        c_rst = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            q0_prev = q0;
            q1_prev = q1;
            ce.cnt = 8'(n % 256);
            ce.m_q = (n % 2) == 1;
            ce.m_wrap = (n % 2) == 0;
            csb.push_back(ce);
            @(posedge CLK);
            #1;
            ce = csb.pop_front();
            check($sformatf("casc%0d", n), 32'({q1, q0}),
                  32'(ce.cnt));
            check($sformatf("casc%0d_adv", n),
                  32'(q1 != q1_prev), 32'(q0_prev == 4'd15));
            check($sformatf("casc%0d_rco0", n), 32'(rco0),
                  32'(ce.cnt[3:0] == 4'd15));
            if (n <= 8) begin
                check($sformatf("m2_%0d_q", n), 32'(m_q),
                      32'(ce.m_q));
                check($sformatf("m2_%0d_wrap", n), 32'(m_wrap),
                      32'(ce.m_wrap));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ttl_sync_counter.md
# ttl_sync_counter

Parametrised synchronous binary up/down counter modelled in the style of the 74xx163/191 family. It is the sequential successor to our fixed-function gate packages and generalises counter width and terminal modulus. It adds parallel load, a direction control, cascade enables, a ripple-carry output and a registered wrap flag. Like our gate packages, it only operates while its supply pins are valid.

## Interface
- WIDTH, 4: counter and data width in bits; minimum 1.
- MODULUS, 2**WIDTH: count modulus; legal range 2 .. 2**WIDTH. Elaboration fails outside this range.

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- VCC  in  1  supply pin; must be 1 for operation.
- GND  in  1  ground pin; must be 0 for operation.
- LOAD_N  in  1  synchronous parallel load, active-low.
- D  in  WIDTH  parallel load data.
- ENP  in  1  count enable, parallel.
- ENT  in  1  count enable, trickle; also gates RCO.
- UP  in  1  direction: 1 counts up, 0 counts down.
- Q  out  WIDTH  counter state (registered).
- RCO  out  1  ripple-carry out (combinational): ENT & terminal-count.
- WRAP  out  1  registered; high for exactly one cycle after a count wraps.

## Operation
- Powered means VCC==1 and GND==0. When not powered, every rising edge is ignored, including RST. Q and WRAP hold their values and RCO is forced to 0.
- Per-edge priority when powered: RST, then load, then count, then hold.
  - RST=1: Q←0, WRAP←0.
  - LOAD_N=0: Q←D, WRAP←0.
  - ENP=1 and ENT=1: count one step.
  - Otherwise: Q holds and WRAP←0.
- Up step:
  - If Q ≥ MODULUS−1: Q←0, WRAP←1.
  - Else: Q←Q+1, WRAP←0.
- Down step:
  - If Q==0: Q←MODULUS−1, WRAP←1.
  - Else: Q←Q−1, WRAP←0.
- Loaded values ≥ MODULUS are accepted verbatim.
  - The next up step wraps to 0.
  - Down steps decrement normally until the count re-enters range.
- Terminal count:
  - TC = (Q==MODULUS−1) when UP=1.
  - TC = (Q==0) when UP=0.
  - RCO = powered & ENT & TC. RCO follows UP and ENT combinationally within the same cycle.
- Cascading: RCO of stage n drives ENT of stage n+1. All stages share CLK, RST and LOAD_N.
- Arithmetic is WIDTH-bit unsigned and never produces a value outside 0 .. 2**WIDTH−1.

## Timing
- Q latency: one clock from sampled inputs to Q.
- WRAP timing: WRAP goes high in the same cycle Q shows the wrapped value and clears on the next edge unless another wrap occurs.
  - With MODULUS=2 and continuous counting, WRAP stays high every other cycle.
- RCO: zero-cycle combinational path from Q, UP, ENT, VCC and GND.
- Reset values:
  - Q=0 and WRAP=0, one edge after RST is sampled high while powered.
  - RCO then equals ENT & ~UP, since Q==0 is terminal when counting down.
  - For MODULUS=1 the up terminal would also apply, but MODULUS=1 is not a legal parameter value.
- Before the first powered reset, Q and WRAP are X. Benches must apply reset after power-valid.
- Reset mid-count: RST overrides LOAD_N and the enables on the same edge. No partial step occurs.
- Simultaneous LOAD_N=0 with ENP=ENT=1: load wins and WRAP←0.
- Power loss mid-operation: state freezes. On power return, counting resumes from the frozen Q, and WRAP keeps its frozen value until the next edge.
- Changing UP between edges: the direction applied is the value of UP at the edge.

## Test plan
- Reset and power: WIDTH=4, with VCC=1, GND=0, RST=1 for 1 edge → Q=0, WRAP=0. With UP=0 and ENT=1, RCO=1. Set VCC=0 and toggle RST/LOAD_N over 3 edges → Q unchanged, RCO=0.
- Up wrap, MODULUS=10: ENP=ENT=UP=1, 12 edges from 0 → Q=1..9,0,1,2. WRAP=1 only in the cycle Q=0. RCO=1 only while Q=9.
- Down wrap and load, MODULUS=10: load D=3, then UP=0 for 5 edges → Q=3,2,1,0,9,8. WRAP=1 only in the cycle Q=9. RCO=1 while Q=0.
- Priority: on one edge drive RST=1, LOAD_N=0, D=7, ENP=ENT=1 → Q=0. Next edge RST=0 → Q=7. Next edge LOAD_N=1 → Q=8.
- Out-of-range load, WIDTH=4, MODULUS=10: load D=13 and count up → Q=0 with WRAP=1. Load D=13 and count down → Q=12.
- Cascade: two WIDTH=4 instances with RCO0→ENT1 and ENP tied high; run 300 edges → {Q1,Q0} equals the edge count mod 256. Stage 1 advances only on edges where Q0=15.
